// File: rtl/vsync_timing_gen_if.sv
// rtl/vsync_timing_gen_if.sv - vertical timing generator signal bundle
interface vsync_timing_gen_if #(
    parameter int yresolution = 10
);
    logic                   LineEnd;
    logic [yresolution-1:0] ActiveVideo;
    logic [yresolution-1:0] FrontPorch;
    logic [yresolution-1:0] SynchPulse;
    logic [yresolution-1:0] BackPorch;
    logic                   vsync;
    logic [yresolution-1:0] yposition;
    logic                   FrameEnd;
    logic                   VerticalActive;
    logic [1:0]             VState;

    modport master (
        output LineEnd, ActiveVideo, FrontPorch, SynchPulse, BackPorch,
        input  vsync, yposition, FrameEnd, VerticalActive, VState
    );

    modport slave (
        input  LineEnd, ActiveVideo, FrontPorch, SynchPulse, BackPorch,
        output vsync, yposition, FrameEnd, VerticalActive, VState
    );
endinterface

// File: rtl/vsync_timing_gen.sv
// rtl/vsync_timing_gen.sv - vertical line counter and phase generator
module vsync_timing_gen #(
    parameter int yresolution = 10
) (
    input  logic                clock,
    input  logic                reset,
    vsync_timing_gen_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } vstate_e;

    localparam logic [yresolution-1:0] ONE = yresolution'(1);

    logic                   line_end_q, line_end_d;
    logic [yresolution-1:0] a_q, a_d, f_q, f_d, s_q, s_d, b_q, b_d;
    logic [yresolution-1:0] ypos_q, ypos_d;
    vstate_e                state_q, state_d;
    logic                   vsync_q, vsync_d;
    logic                   frame_end_q, frame_end_d;

    logic                   line_event;
    logic                   at_end;
    logic [yresolution-1:0] a_f, a_f_s, end_count, yn;
    vstate_e                phase_next;

    assign line_event = bus.LineEnd & ~line_end_q;
    assign a_f        = a_q + f_q;
    assign a_f_s      = a_f + s_q;
    assign end_count  = a_f_s + b_q;
    assign at_end     = (ypos_q == end_count);
    assign yn         = at_end ? '0 : ypos_q + ONE;

    // Ordered compares make zero-length phases fall through naturally.
    always_comb begin
        phase_next = ST_BACK;
        if (yn < a_q) begin
            phase_next = ST_ACTIVE;
        end else if (yn < a_f) begin
            phase_next = ST_FRONT;
        end else if (yn < a_f_s) begin
            phase_next = ST_SYNC;
        end
    end

    always_comb begin
        line_end_d  = bus.LineEnd;
        a_d         = a_q;
        f_d         = f_q;
        s_d         = s_q;
        b_d         = b_q;
        ypos_d      = ypos_q;
        state_d     = state_q;
        vsync_d     = vsync_q;
        frame_end_d = 1'b0;
        if (line_event) begin
            ypos_d      = yn;
            state_d     = phase_next;
            vsync_d     = (phase_next != ST_SYNC);
            frame_end_d = at_end;
            if (at_end) begin
                a_d = bus.ActiveVideo;
                f_d = bus.FrontPorch;
                s_d = bus.SynchPulse;
                b_d = bus.BackPorch;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            line_end_q  <= 1'b0;
            a_q         <= bus.ActiveVideo;
            f_q         <= bus.FrontPorch;
            s_q         <= bus.SynchPulse;
            b_q         <= bus.BackPorch;
            ypos_q      <= '0;
            state_q     <= ST_ACTIVE;
            vsync_q     <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            line_end_q  <= line_end_d;
            a_q         <= a_d;
            f_q         <= f_d;
            s_q         <= s_d;
            b_q         <= b_d;
            ypos_q      <= ypos_d;
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign bus.yposition      = ypos_q;
    assign bus.VState         = state_q;
    assign bus.vsync          = vsync_q;
    assign bus.FrameEnd       = frame_end_q;
    assign bus.VerticalActive = (state_q == ST_ACTIVE);
endmodule

// File: tb/tb_vsync_timing_gen.sv
// tb/tb_vsync_timing_gen.sv - scoreboard bench for vsync_timing_gen
module tb_vsync_timing_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        string name;
        int    y;
        int    st;
        int    vs;
        int    fe;
    } exp_t;

    exp_t sb_q[$];

    vsync_timing_gen_if #(.yresolution(10)) vif ();

    vsync_timing_gen #(.yresolution(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string n, input string f, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, req);
        end
    endtask

    always begin
        @(negedge clock);
        #1;
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp(e.name, "yposition", int'(vif.yposition), e.y);
            cmp(e.name, "VState", int'(vif.VState), e.st);
            cmp(e.name, "vsync", int'(vif.vsync), e.vs);
            cmp(e.name, "FrameEnd", int'(vif.FrameEnd), e.fe);
            cmp(e.name, "VerticalActive", int'(vif.VerticalActive), (e.st == 0) ? 1 : 0);
        end
    end

    task automatic expect_out(input string n, input int y, input int st, input int vs, input int fe);
        exp_t e;
        e.name = n; e.y = y; e.st = st; e.vs = vs; e.fe = fe;
        sb_q.push_back(e);
    endtask

    task automatic line_pulse();
        @(negedge clock) vif.LineEnd = 1'b1;
        @(negedge clock) vif.LineEnd = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) line_pulse();
    endtask

    task automatic do_reset();
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        @(negedge clock) reset = 1'b0;
    endtask

    initial begin
        vif.LineEnd     = 1'b0;
        vif.ActiveVideo = 10'd480;
        vif.FrontPorch  = 10'd10;
        vif.SynchPulse  = 10'd2;
        vif.BackPorch   = 10'd33;

        do_reset();
        expect_out("reset", 0, 0, 1, 0);

        pulses(489);
        expect_out("y489", 489, 1, 1, 0);
        line_pulse();
        expect_out("y490", 490, 2, 0, 0);
        pulses(2);
        expect_out("y492", 492, 3, 1, 0);

        do_reset();
        pulses(7);
        expect_out("y7", 7, 0, 1, 0);
        @(negedge clock) vif.LineEnd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            expect_out("held", 8, 0, 1, 0);
        end
        vif.LineEnd = 1'b0;
        @(negedge clock);
        expect_out("held_low", 8, 0, 1, 0);
        line_pulse();
        expect_out("after_held", 9, 0, 1, 0);

        pulses(516);
        expect_out("y525", 525, 3, 1, 0);
        line_pulse();
        expect_out("wrap", 0, 0, 1, 1);
        @(negedge clock);
        expect_out("wrap_next", 0, 0, 1, 0);

        pulses(100);
        expect_out("y100", 100, 0, 1, 0);
        vif.ActiveVideo = 10'd400;
        pulses(389);
        expect_out("midchg489", 489, 1, 1, 0);
        line_pulse();
        expect_out("midchg490", 490, 2, 0, 0);
        pulses(35);
        expect_out("midchg525", 525, 3, 1, 0);
        line_pulse();
        expect_out("midchg_wrap", 0, 0, 1, 1);
        pulses(399);
        expect_out("new399", 399, 0, 1, 0);
        line_pulse();
        expect_out("new400", 400, 1, 1, 0);
        pulses(45);
        expect_out("new445", 445, 3, 1, 0);
        line_pulse();
        expect_out("new_wrap", 0, 0, 1, 1);

        vif.ActiveVideo = 10'd480;
        vif.FrontPorch  = 10'd0;
        do_reset();
        pulses(479);
        expect_out("f0_479", 479, 0, 1, 0);
        line_pulse();
        expect_out("f0_480", 480, 2, 0, 0);
        line_pulse();
        expect_out("f0_481", 481, 2, 0, 0);
        line_pulse();
        expect_out("f0_482", 482, 3, 1, 0);
        pulses(33);
        expect_out("f0_515", 515, 3, 1, 0);
        line_pulse();
        expect_out("f0_wrap", 0, 0, 1, 1);

        vif.FrontPorch = 10'd10;
        pulses(300);
        expect_out("y300", 300, 0, 1, 0);
        @(negedge clock);
        reset = 1'b1;
        vif.LineEnd = 1'b1;
        @(negedge clock);
        expect_out("rst_evt", 0, 0, 1, 0);
        reset = 1'b0;
        vif.LineEnd = 1'b0;
        @(negedge clock);
        expect_out("rst_after", 0, 0, 1, 0);
        line_pulse();
        expect_out("rst_first", 1, 0, 1, 0);

        repeat (3) @(negedge clock);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vsync_timing_gen.md
VSYNC_TIMING_GEN -- requirements
Module: vsync_timing_gen

Interface
REQ-001 Parameter yresolution, default 10, width of the line counter and of all vertical timing inputs.
REQ-002 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port LineEnd  input  1  end-of-line indication from the horizontal timing stage; level signal that may stay high for one or more clocks.
REQ-005 Ports ActiveVideo, FrontPorch, SynchPulse, BackPorch  input  yresolution each  vertical timing lengths in lines.
REQ-006 Port vsync  output  1  vertical sync, active low, registered.
REQ-007 Port yposition  output  yresolution  current line number, registered.
REQ-008 Port FrameEnd  output  1  one-clock pulse at frame wrap, registered.
REQ-009 Port VerticalActive  output  1  high while in the ACTIVE phase.
REQ-010 Port VState  output  2  current phase: ACTIVE=0, FRONT=1, SYNC=2, BACK=3.

Function
REQ-011 A line event is the rising edge of LineEnd, detected against a registered copy of LineEnd, which resets to 0.
REQ-012 All counter, state, vsync and FrameEnd updates occur on the clock edge where a line event is detected; no other edge changes them except reset.
REQ-013 Shadow registers hold A, F, S and B; they load from the timing inputs on reset and on the clock edge where the frame wraps; all decoding uses the shadow values only.
REQ-014 EndCount = A+F+S+B, computed in yresolution bits; a sum exceeding 2^yresolution-1 is unsupported.
REQ-015 yposition counts 0..EndCount inclusive, incrementing by 1 per line event.
REQ-016 On a line event with yposition==EndCount, yposition becomes 0 and FrameEnd is 1 for exactly that following cycle; otherwise FrameEnd is 0.
REQ-017 Phase decode of the next y value (yn): ACTIVE if yn<A; FRONT if A<=yn<A+F; SYNC if A+F<=yn<A+F+S; BACK otherwise.
REQ-018 VState and vsync are registered from yn on the same edge as yposition, so all three change together.
REQ-019 vsync is 0 exactly when VState==SYNC, otherwise 1.
REQ-020 VerticalActive is 1 exactly when VState==ACTIVE.
REQ-021 A zero-length phase is skipped; e.g. F=0 goes ACTIVE->SYNC directly.
REQ-022 S=0 never drives vsync low.
REQ-023 A=0 is unsupported.
REQ-024 Timing-input changes mid-frame have no effect until the next frame wrap.
REQ-025 A LineEnd held high for N clocks produces exactly one line event.
REQ-026 A LineEnd that toggles every clock produces one event per rising edge.

Reset
REQ-027 On a clock edge with reset high, the block sets:
- yposition=0
- VState=ACTIVE
- VerticalActive=1
- vsync=1
- FrameEnd=0
- LineEnd history register=0
- shadow registers loaded from the inputs.
REQ-028 reset has priority over a simultaneous line event; that event is discarded.
REQ-029 Reset asserted mid-frame returns all outputs to their reset values on the next clock edge, regardless of phase.

Verification
All scenarios use A=480, F=10, S=2, B=33, so EndCount=525, unless stated otherwise.
REQ-030 Reset for 2 clocks -> yposition=0, vsync=1, VState=0, FrameEnd=0, VerticalActive=1.
REQ-031 490 single-clock LineEnd pulses -> yposition=490, VState=2, vsync=0; 2 more pulses -> yposition=492, VState=3, vsync=1.
REQ-032 LineEnd held high 5 clocks from yposition=7 -> yposition=8, unchanged afterwards until LineEnd falls and rises again.
REQ-033 Line events from 0 to 525, then one more event -> yposition wraps to 0, FrameEnd high exactly one clock, VState=0.
REQ-034 ActiveVideo changed to 400 at yposition=100 -> SYNC still begins at 490 in this frame; in the next frame FRONT begins at 400.
REQ-035 F=0 (EndCount=515) -> VState goes 0->2 at yposition=480, vsync low for lines 480-481.
REQ-036 reset pulsed at yposition=300 with a simultaneous line event -> yposition=0, VState=0 on that edge; no line counted.
